kth_largest_alu: RTL and testbench

- Parametrised successor of the third-largest ALU datapath.
- A run begins with a start pulse carrying an item count and a rank k.
- Each accepted valid beat computes one ALU result from data_A/data_B under a 4-bit instruction and inserts it into a sorted top-K_MAX list.
- After the last item, the block reports the k-th largest result with a one-cycle finish pulse; it sits behind the pattern-feeding front end in the same place as its predecessor.

---
 rtl/kth_largest_alu.sv | 192 +++++++++++++++++++
 tb/tb_kth_largest_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/kth_largest_alu.sv
// Streaming ALU that ranks each run's results in a descending top-K_MAX list
// and reports the k-th largest one with a single-cycle finish pulse.
module kth_largest_alu #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int K_MAX  = 4,
    parameter int KS_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic [KS_W-1:0]   k_sel,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_A,
    input  logic [DATA_W-1:0] data_B,
    input  logic [3:0]        instruction,
    output logic [DATA_W-1:0] kth_largest,
    output logic              finish,
    output logic              underflow,
    output logic              illegal_op,
    output logic [1:0]        state_dbg
);

    // Handshake: an item is taken on any rising edge where valid=1 while in
    // RUN and the run is not yet complete; there is no ready, so the source
    // must hold each item for exactly one accepted edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [KS_W-1:0] K_MAX_V = KS_W'(K_MAX);

    state_t              state_q, state_d;
    logic                accept, clear;
    logic [CNT_W-1:0]    cnt_r, acc_cnt, acc_next;
    logic [KS_W-1:0]     k_r, k_eff;
    logic [DATA_W-1:0]   alu_res, alu_r, sel_val;
    logic                s1_valid, illegal_run, enough;
    logic [DATA_W-1:0]   list_q [K_MAX];
    logic [DATA_W-1:0]   list_d [K_MAX];
    logic [K_MAX-1:0]    occ_q, occ_d, ins;
    logic [2*DATA_W-1:0] prod;

    assign state_dbg = state_q;
    assign acc_next  = acc_cnt + 1'b1;

    always_comb begin
        if (k_sel == '0)
            k_eff = KS_W'(1);
        else if (k_sel > K_MAX_V)
            k_eff = K_MAX_V;
        else
            k_eff = k_sel;
    end

    always_comb begin
        prod = {{DATA_W{1'b0}}, data_A} * {{DATA_W{1'b0}}, data_B};
        case (instruction)
            4'd0:    alu_res = data_A + data_B;
            4'd1:    alu_res = data_A - data_B;
            4'd2:    alu_res = data_A & data_B;
            4'd3:    alu_res = data_A | data_B;
            4'd4:    alu_res = data_A ^ data_B;
            4'd5:    alu_res = (data_A >= data_B) ? data_A : data_B;
            4'd6:    alu_res = (data_A <= data_B) ? data_A : data_B;
            4'd7:    alu_res = (data_A >= data_B) ? (data_A - data_B) : (data_B - data_A);
            4'd8:    alu_res = prod[DATA_W-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = (count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                // A restart takes priority; a valid in the same cycle is dropped.
                if (start) begin
                    clear   = 1'b1;
                    state_d = (count == '0) ? DRAIN : RUN;
                end else if (valid) begin
                    accept = 1'b1;
                    if (acc_next == cnt_r)
                        state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Parallel compare-and-shift: every slot the new value beats moves down one.
    always_comb begin
        for (int i = 0; i < K_MAX; i++)
            ins[i] = !occ_q[i] || (alu_r > list_q[i]);
        list_d[0] = ins[0] ? alu_r : list_q[0];
        occ_d[0]  = ins[0] ? 1'b1  : occ_q[0];
        for (int i = 1; i < K_MAX; i++) begin
            if (!ins[i]) begin
                list_d[i] = list_q[i];
                occ_d[i]  = occ_q[i];
            end else if (ins[i-1]) begin
                list_d[i] = list_q[i-1];
                occ_d[i]  = occ_q[i-1];
            end else begin
                list_d[i] = alu_r;
                occ_d[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < K_MAX; i++)
            if (KS_W'(i + 1) == k_r)
                sel_val = list_q[i];
        enough = (32'(acc_cnt) >= 32'(k_r));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            acc_cnt     <= '0;
            k_r         <= '0;
            alu_r       <= '0;
            s1_valid    <= 1'b0;
            illegal_run <= 1'b0;
            occ_q       <= '0;
            for (int i = 0; i < K_MAX; i++)
                list_q[i] <= '0;
        end else if (clear) begin
            cnt_r       <= count;
            k_r         <= k_eff;
            acc_cnt     <= '0;
            s1_valid    <= 1'b0;
            illegal_run <= 1'b0;
            occ_q       <= '0;
            for (int i = 0; i < K_MAX; i++)
                list_q[i] <= '0;
        end else begin
            if (s1_valid) begin
                occ_q <= occ_d;
                for (int i = 0; i < K_MAX; i++)
                    list_q[i] <= list_d[i];
            end
            s1_valid <= accept;
            if (accept) begin
                alu_r   <= alu_res;
                acc_cnt <= acc_next;
                if (instruction >= 4'd9)
                    illegal_run <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kth_largest <= '0;
            finish      <= 1'b0;
            underflow   <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (state_q == DONE) begin
            finish      <= 1'b1;
            kth_largest <= enough ? sel_val : '0;
            underflow   <= !enough;
            illegal_op  <= illegal_run;
        end else begin
            finish <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kth_largest_alu.sv
// Directed bench for kth_largest_alu: hand-computed runs covering ranking,
// rank clamping, underflow, reserved opcodes, restart and asynchronous reset.
module tb_kth_largest_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic [2:0] k_sel;
    logic       valid;
    logic [7:0] data_A, data_B;
    logic [3:0] instruction;
    logic [7:0] kth_largest;
    logic       finish, underflow, illegal_op;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    kth_largest_alu #(.DATA_W(8), .CNT_W(8), .K_MAX(4), .KS_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .k_sel(k_sel),
        .valid(valid), .data_A(data_A), .data_B(data_B),
        .instruction(instruction), .kth_largest(kth_largest),
        .finish(finish), .underflow(underflow), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] c, input logic [2:0] k);
        start = 1'b1; count = c; k_sel = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic item(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        valid = 1'b1; instruction = op; data_A = a; data_B = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Waits for finish, checks its latency in cycles, the results, and that it drops next cycle.
    task automatic wait_finish(input string tag, input int exp_lat, input logic [7:0] exp_kth,
                               input logic exp_uf, input logic exp_ill);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!finish && lat < 20);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_kth"}, kth_largest, exp_kth);
        chk({tag, "_underflow"}, underflow, exp_uf);
        chk({tag, "_illegal"}, illegal_op, exp_ill);
        @(negedge clk);
        chk({tag, "_finish_drop"}, finish, 1'b0);
    endtask

    task automatic no_finish(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (finish) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; k_sel = '0; valid = 1'b0;
        data_A = '0; data_B = '0; instruction = '0;
        repeat (3) @(negedge clk);
        chk("reset_kth", kth_largest, 8'd0);
        chk("reset_finish", finish, 1'b0);
        chk("reset_underflow", underflow, 1'b0);
        chk("reset_illegal", illegal_op, 1'b0);
        chk("reset_state", state_dbg, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        // Results 7, 8, 255, 5 -> sorted 255,8,7,5
        do_start(8'd4, 3'd3);
        item(4'd0, 8'd3, 8'd4); item(4'd1, 8'd10, 8'd2);
        item(4'd4, 8'h0F, 8'hF0); item(4'd6, 8'd5, 8'd9);
        wait_finish("basic_k3", 2, 8'd7, 1'b0, 1'b0);

        // Same items with gaps in valid
        do_start(8'd4, 3'd3);
        item(4'd0, 8'd3, 8'd4); @(negedge clk);
        item(4'd1, 8'd10, 8'd2); @(negedge clk);
        item(4'd4, 8'h0F, 8'hF0); @(negedge clk);
        item(4'd6, 8'd5, 8'd9);
        wait_finish("gaps_k3", 2, 8'd7, 1'b0, 1'b0);

        do_start(8'd4, 3'd1);
        item(4'd0, 8'd3, 8'd4); item(4'd1, 8'd10, 8'd2);
        item(4'd4, 8'h0F, 8'hF0); item(4'd6, 8'd5, 8'd9);
        wait_finish("basic_k1", 2, 8'd255, 1'b0, 1'b0);

        do_start(8'd4, 3'd4);
        item(4'd0, 8'd3, 8'd4); item(4'd1, 8'd10, 8'd2);
        item(4'd4, 8'h0F, 8'hF0); item(4'd6, 8'd5, 8'd9);
        wait_finish("basic_k4", 2, 8'd5, 1'b0, 1'b0);

        // 44, 247, 16; an extra valid of 255 after the last item must be ignored
        do_start(8'd3, 3'd2);
        item(4'd0, 8'd200, 8'd100); item(4'd7, 8'd3, 8'd250); item(4'd8, 8'd16, 8'd17);
        item(4'd0, 8'd250, 8'd5);
        wait_finish("wrap_k2", 1, 8'd44, 1'b0, 1'b0);

        // AND 0x30, OR 0xAA, SUB wrap 0xFF, ABS 150 -> sorted FF,AA,96,30
        do_start(8'd4, 3'd3);
        item(4'd2, 8'hF0, 8'h3C); item(4'd3, 8'hA0, 8'h0A);
        item(4'd1, 8'd2, 8'd3); item(4'd7, 8'd200, 8'd50);
        wait_finish("logic_k3", 2, 8'd150, 1'b0, 1'b0);

        // Duplicates occupy separate slots
        do_start(8'd3, 3'd3);
        item(4'd5, 8'd9, 8'd2); item(4'd5, 8'd9, 8'd2); item(4'd5, 8'd9, 8'd2);
        wait_finish("dups_k3", 2, 8'd9, 1'b0, 1'b0);

        // k_sel=7 clamps to 4; 1 is dropped from the full list
        do_start(8'd5, 3'd7);
        for (int i = 1; i <= 5; i++) item(4'd0, 8'(i), 8'd0);
        wait_finish("clamp_k7", 2, 8'd2, 1'b0, 1'b0);

        do_start(8'd2, 3'd3);
        item(4'd0, 8'd1, 8'd1); item(4'd0, 8'd2, 8'd2);
        wait_finish("underflow", 2, 8'd0, 1'b1, 1'b0);

        do_start(8'd0, 3'd0);
        wait_finish("count_zero", 2, 8'd0, 1'b1, 1'b0);

        // Reserved opcode inserts 0 -> list 6,0
        do_start(8'd2, 3'd2);
        item(4'd12, 8'd5, 8'd5); item(4'd0, 8'd3, 8'd3);
        wait_finish("illegal_op", 2, 8'd0, 1'b0, 1'b1);

        // Restart mid-run; the valid in the restart cycle is dropped
        do_start(8'd4, 3'd3);
        item(4'd0, 8'd50, 8'd50); item(4'd0, 8'd100, 8'd100);
        start = 1'b1; count = 8'd1; k_sel = 3'd1;
        valid = 1'b1; instruction = 4'd0; data_A = 8'd50; data_B = 8'd50;
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        item(4'd0, 8'd1, 8'd1);
        wait_finish("restart", 2, 8'd2, 1'b0, 1'b0);
        no_finish("restart_single", 6);

        // Asynchronous reset mid-run
        do_start(8'd3, 3'd1);
        item(4'd0, 8'd7, 8'd7); item(4'd0, 8'd8, 8'd8);
        #2 rst = 1'b1;
        #1;
        chk("midrst_kth", kth_largest, 8'd0);
        chk("midrst_finish", finish, 1'b0);
        chk("midrst_state", state_dbg, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        item(4'd0, 8'd9, 8'd9);
        no_finish("midrst_no_finish", 8);
        do_start(8'd1, 3'd1);
        item(4'd3, 8'hA0, 8'h0A);
        wait_finish("after_rst", 2, 8'hAA, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
